// File: rtl/key_event_encoder.sv
// key_event_encoder: scans a debounced active-low key vector against a
// snapshot of the last reported state and queues press/release events.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   keys_i       debounced keys, 0 = pressed, 1 = released
//   evt_valid_o  FIFO head holds an event
//   evt_ready_i  consumer takes the head event this cycle
//   evt_data_o   {press, key index}, first-word-fall-through
//   fifo_level_o entries currently queued
//   stall_o      scanner is blocked on a full FIFO
module key_event_encoder #(
  parameter int KEYS  = 61,
  parameter int IDX_W = 7,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [KEYS-1:0]            keys_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [IDX_W:0]             evt_data_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o,
  output logic                       stall_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(KEYS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(KEYS - 1);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [KEYS-1:0]  snap;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] scan_nxt;
  logic [SW-1:0]    sel;

  logic [IDX_W:0]   mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;

  logic cur;
  logic diff;
  logic full;
  logic empty;
  logic push;
  logic pop;

  // scan_idx never exceeds KEYS-1, so its low bits address the vector
  assign sel   = scan_idx[SW-1:0];
  assign cur   = keys_i[sel];
  assign diff  = cur ^ snap[sel];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // push is gated on the pre-edge full flag even when a pop
  // happens in the same cycle
  assign push  = diff & ~full;
  assign pop   = ~empty & evt_ready_i;

  assign scan_nxt = (scan_idx == LAST) ? '0 : scan_idx + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap     <= '1;
      scan_idx <= '0;
    end else begin
      if (push) begin
        snap[sel] <= cur;
      end
      // hold position while a difference waits for FIFO space
      if (!(diff && full)) begin
        scan_idx <= scan_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {~cur, scan_idx};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign evt_valid_o  = ~empty;
  assign evt_data_o   = empty ? '0 : mem[rd_ptr];
  assign fifo_level_o = count;
  assign stall_o      = diff & full;

endmodule

// File: doc/key_event_encoder.md
Name: key_event_encoder

Overview:
- Sits directly downstream of the key debouncer and consumes its 61-bit debounced, active-low key vector.
- Round-robin scans the vector against a snapshot of the last reported state.
- Each difference becomes an 8-bit press/release event, pushed into an internal FWFT FIFO.
- A valid/ready stream presents the events to the report/transport logic.

Parameters:
- KEYS, 61: number of key inputs; must be <= 2^IDX_W.
- IDX_W, 7: width of the key index field in an event.
- DEPTH, 16: event FIFO depth in entries; must be a power of two and >= 2.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- keys_i  input  KEYS  debounced key states; 0 = pressed, 1 = released.
- evt_valid_o  output  1  FIFO head holds an event.
- evt_ready_i  input  1  consumer accepts the head event this cycle.
- evt_data_o  output  IDX_W+1  event: bit IDX_W = 1 press / 0 release; bits IDX_W-1:0 = key index.
- fifo_level_o  output  $clog2(DEPTH)+1  number of entries currently stored.
- stall_o  output  1  scanner is blocked on a full FIFO.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values:
  - snapshot = all ones (all keys released); scan_idx = 0.
  - FIFO rd_ptr = wr_ptr = count = 0.
  - evt_valid_o = 0, fifo_level_o = 0, stall_o = 0, evt_data_o = 0.
- Reset asserted mid-operation: all queued events are discarded and the snapshot is re-initialised. Keys still held after reset are re-reported as presses on the next scan.
- Scanner: each cycle it examines index i = scan_idx and computes diff = keys_i[i] XOR snapshot[i].
  - diff = 0: scan_idx advances.
  - diff = 1 and FIFO not full: push {~keys_i[i], i}, set snapshot[i] = keys_i[i], advance scan_idx.
  - diff = 1 and FIFO full: no push, snapshot unchanged, scan_idx holds, stall_o = 1 (combinational).
  - Events are never dropped. Order of detection is preserved.
- Scan advance: scan_idx goes from KEYS-1 to 0, never visiting indices >= KEYS. A full pass takes KEYS cycles when unstalled.
- Pending changes: a key changing twice before the scanner reaches it (e.g. press then release) yields no event, because only the state difference at sample time is reported.
- FIFO latency and output:
  - An event pushed on edge N gives evt_valid_o = 1 in the cycle after edge N.
  - Output is first-word-fall-through: evt_data_o = mem[rd_ptr]. evt_data_o is don't-care when evt_valid_o = 0; the bench checks it only when valid.
- Handshake:
  - A pop occurs on a rising edge with evt_valid_o & evt_ready_i.
  - evt_data_o stays stable while evt_valid_o = 1 and evt_ready_i = 0.
  - evt_ready_i is ignored when the FIFO is empty.
- Full/empty rules:
  - full = (count == DEPTH) and empty = (count == 0), both evaluated before the current edge.
  - Push is gated by !full even if a pop happens in the same cycle, so a full FIFO needs one cycle to unstall.
  - Push and pop in the same cycle when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is $clog2(DEPTH)+1 bits. fifo_level_o = count.

Test Plan:
1. Reset release, keys_i = all ones, evt_ready_i = 1 for 200 cycles -> evt_valid_o stays 0, fifo_level_o = 0, stall_o = 0 throughout.
2. keys_i[5] = 0 held from reset release -> exactly one event 8'h85 (press, index 5), valid after the 6th edge. Then set keys_i[5] = 1 -> exactly one event 8'h05. No duplicates over a further 3 scan passes.
3. Keys 0, 3 and 60 pressed together, ready = 1 -> events 8'h80, 8'h83, 8'hBC in that order within one 61-cycle pass.
4. evt_ready_i = 0, and 20 keys (indices 0-19) pressed:
   - fifo_level_o reaches 16; stall_o = 1 with scan_idx held at 16.
   - Then ready = 1 -> all 20 events drain in index order 0..19, none lost, fifo_level_o returns to 0, stall_o clears.
5. Head 8'h82 valid with ready = 0 for 10 cycles -> evt_data_o holds 8'h82 each cycle. Pulse ready for one cycle -> exactly one pop, fifo_level_o decrements by 1.
6. With 4 queued events and keys 10-12 held low, assert rst_i asynchronously mid-cycle:
   - evt_valid_o and fifo_level_o go to 0 immediately.
   - After release, events 8'h8A, 8'h8B, 8'h8C are re-reported.
